// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizes and sample types for the 512-point streaming FFT
package fft_pkg;
  localparam int N          = 512;
  localparam int LANES      = 16;
  localparam int IN_W       = 9;
  localparam int OUT_W      = IN_W + 1;
  localparam int HALF_BEATS = N / (2 * LANES);
  localparam int CNT_W      = $clog2(2 * HALF_BEATS);
  localparam int IDX_W      = $clog2(HALF_BEATS);

  typedef logic signed [IN_W-1:0]  sample_in_t;
  typedef logic signed [OUT_W-1:0] sample_out_t;
endpackage

// File: rtl/bfly2_lane.sv
// rtl/bfly2_lane.sv - one-lane complex radix-2 add/sub with sign extension
module bfly2_lane
  import fft_pkg::*;
(
  input  logic [IN_W-1:0]  a_r_i,
  input  logic [IN_W-1:0]  a_q_i,
  input  logic [IN_W-1:0]  b_r_i,
  input  logic [IN_W-1:0]  b_q_i,
  output logic [OUT_W-1:0] add_r_o,
  output logic [OUT_W-1:0] add_q_o,
  output logic [OUT_W-1:0] sub_r_o,
  output logic [OUT_W-1:0] sub_q_o
);
  // One guard bit makes every sum and difference of two IN_W values exact.
  sample_out_t a_r_x, a_q_x, b_r_x, b_q_x;

  assign a_r_x = {a_r_i[IN_W-1], a_r_i};
  assign a_q_x = {a_q_i[IN_W-1], a_q_i};
  assign b_r_x = {b_r_i[IN_W-1], b_r_i};
  assign b_q_x = {b_q_i[IN_W-1], b_q_i};

  assign add_r_o = a_r_x + b_r_x;
  assign add_q_o = a_q_x + b_q_x;
  assign sub_r_o = a_r_x - b_r_x;
  assign sub_q_o = a_q_x - b_q_x;
endmodule

// File: rtl/step0_0.sv
// rtl/step0_0.sv - first DIF butterfly stage: buffer half a frame, emit x[n]+/-x[n+256]
module step0_0
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din_i [LANES],
  input  logic [IN_W-1:0]  din_q [LANES],
  output logic [OUT_W-1:0] dout_add_r [LANES],
  output logic [OUT_W-1:0] dout_add_i [LANES],
  output logic [OUT_W-1:0] dout_sub_r [LANES],
  output logic [OUT_W-1:0] dout_sub_i [LANES],
  output logic             dout_valid,
  output logic             bufly_enable
);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              bufly_q, bufly_d;
  logic              fire;
  logic [IDX_W-1:0]  idx;

  // Each entry packs {imag, real} for one lane of one first-half beat.
  logic [2*IN_W-1:0] buf_q [HALF_BEATS][LANES];

  logic [OUT_W-1:0]  add_r_w [LANES];
  logic [OUT_W-1:0]  add_q_w [LANES];
  logic [OUT_W-1:0]  sub_r_w [LANES];
  logic [OUT_W-1:0]  sub_q_w [LANES];
  logic [OUT_W-1:0]  add_r_q [LANES];
  logic [OUT_W-1:0]  add_q_q [LANES];
  logic [OUT_W-1:0]  sub_r_q [LANES];
  logic [OUT_W-1:0]  sub_q_q [LANES];

  assign idx = cnt_q[IDX_W-1:0];

  always_comb begin
    cnt_d   = cnt_q;
    fire    = 1'b0;
    valid_d = 1'b0;
    bufly_d = 1'b0;
    if (din_valid) begin
      cnt_d   = cnt_q + CNT_W'(1);
      fire    = cnt_q[CNT_W-1];
      valid_d = fire;
      bufly_d = fire && (idx == '0);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bfly2_lane u_bfly (
      .a_r_i   (buf_q[idx][l][IN_W-1:0]),
      .a_q_i   (buf_q[idx][l][2*IN_W-1:IN_W]),
      .b_r_i   (din_i[l]),
      .b_q_i   (din_q[l]),
      .add_r_o (add_r_w[l]),
      .add_q_o (add_q_w[l]),
      .sub_r_o (sub_r_w[l]),
      .sub_q_o (sub_q_w[l])
    );
  end

  always_ff @(posedge clk) begin
    if (din_valid && !cnt_q[CNT_W-1]) begin
      for (int l = 0; l < LANES; l++) begin
        buf_q[idx][l] <= {din_q[l], din_i[l]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      bufly_q <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        add_r_q[l] <= '0;
        add_q_q[l] <= '0;
        sub_r_q[l] <= '0;
        sub_q_q[l] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      bufly_q <= bufly_d;
      if (fire) begin
        for (int l = 0; l < LANES; l++) begin
          add_r_q[l] <= add_r_w[l];
          add_q_q[l] <= add_q_w[l];
          sub_r_q[l] <= sub_r_w[l];
          sub_q_q[l] <= sub_q_w[l];
        end
      end
    end
  end

  assign dout_add_r   = add_r_q;
  assign dout_add_i   = add_q_q;
  assign dout_sub_r   = sub_r_q;
  assign dout_sub_i   = sub_q_q;
  assign dout_valid   = valid_q;
  assign bufly_enable = bufly_q;
endmodule

// File: tb/tb_step0_0.sv
// tb/tb_step0_0.sv - directed table-driven bench for the step0_0 butterfly stage
module tb_step0_0;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       din_valid = 1'b0;
  logic [8:0] din_i [16];
  logic [8:0] din_q [16];
  logic [9:0] dout_add_r [16];
  logic [9:0] dout_add_i [16];
  logic [9:0] dout_sub_r [16];
  logic [9:0] dout_sub_i [16];
  logic       dout_valid;
  logic       bufly_enable;

  step0_0 dut (
    .clk          (clk),
    .rstn         (rstn),
    .din_valid    (din_valid),
    .din_i        (din_i),
    .din_q        (din_q),
    .dout_add_r   (dout_add_r),
    .dout_add_i   (dout_add_i),
    .dout_sub_r   (dout_sub_r),
    .dout_sub_i   (dout_sub_i),
    .dout_valid   (dout_valid),
    .bufly_enable (bufly_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    int beat;
    int lane;
    int ar;
    int ai;
    int sr;
    int si;
  } vec_t;

  vec_t       tbl [5];
  int         n_checks = 0;
  int         n_pass = 0;
  int         bufly_total = 0;
  logic [8:0] vi [32][16];
  logic [8:0] vq [32][16];
  logic [9:0] cap_ar [16][16];
  logic [9:0] cap_ai [16][16];
  logic [9:0] cap_sr [16][16];
  logic [9:0] cap_si [16][16];

  function automatic int sx9(logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sx10(logic [9:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill_ramp();
    for (int j = 0; j < 32; j++)
      for (int i = 0; i < 16; i++) begin
        vi[j][i] = 9'(i + 16 * j);
        vq[j][i] = 9'(100 + i + 16 * j);
      end
  endtask

  task automatic clear_cap();
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++) begin
        cap_ar[k][i] = '0; cap_ai[k][i] = '0; cap_sr[k][i] = '0; cap_si[k][i] = '0;
      end
  endtask

  task automatic run_frame(input bit gaps, input string tag);
    int nvalid = 0;
    int nbufly = 0;
    int first = -1;
    int bad = 0;
    for (int j = 0; j < 32; j++) begin
      din_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
        din_i[i] = vi[j][i];
        din_q[i] = vq[j][i];
      end
      @(posedge clk); #1;
      if (dout_valid) begin
        nvalid++;
        if (first < 0) first = j;
        if (j >= 16)
          for (int i = 0; i < 16; i++) begin
            cap_ar[j-16][i] = dout_add_r[i];
            cap_ai[j-16][i] = dout_add_i[i];
            cap_sr[j-16][i] = dout_sub_r[i];
            cap_si[j-16][i] = dout_sub_i[i];
          end
      end
      if (bufly_enable) begin
        nbufly++;
        if (!dout_valid || j != 16) bad++;
      end
      if (dout_valid != (j >= 16)) bad++;
      if (gaps && (j == 5 || j == 20)) begin
        repeat (3) begin
          din_valid = 1'b0;
          for (int i = 0; i < 16; i++) begin
            din_i[i] = 9'($urandom);
            din_q[i] = 9'($urandom);
          end
          @(posedge clk); #1;
          if (dout_valid || bufly_enable) bad++;
          if (j == 20 && sx10(dout_add_r[0]) != sx9(vi[4][0]) + sx9(vi[20][0])) bad++;
          if (j == 20 && sx10(dout_sub_i[7]) != sx9(vq[4][7]) - sx9(vq[20][7])) bad++;
        end
      end
    end
    din_valid = 1'b0;
    check({tag, " valid_count"}, nvalid, 16);
    check({tag, " first_valid_beat"}, first, 16);
    check({tag, " bufly_count"}, nbufly, 1);
    check({tag, " protocol_errors"}, bad, 0);
    bufly_total += nbufly;
  endtask

  task automatic check_model(input string tag);
    int bad = 0;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 16; i++) begin
        if (sx10(cap_ar[k][i]) != sx9(vi[k][i]) + sx9(vi[k+16][i])) bad++;
        if (sx10(cap_ai[k][i]) != sx9(vq[k][i]) + sx9(vq[k+16][i])) bad++;
        if (sx10(cap_sr[k][i]) != sx9(vi[k][i]) - sx9(vi[k+16][i])) bad++;
        if (sx10(cap_si[k][i]) != sx9(vq[k][i]) - sx9(vq[k+16][i])) bad++;
      end
    check({tag, " model_mismatches"}, bad, 0);
  endtask

  task automatic check_table(input string tag);
    for (int t = 0; t < 5; t++) begin
      int k = tbl[t].beat - 16;
      int l = tbl[t].lane;
      check($sformatf("%s b%0d l%0d add_r", tag, tbl[t].beat, l), sx10(cap_ar[k][l]), tbl[t].ar);
      check($sformatf("%s b%0d l%0d add_i", tag, tbl[t].beat, l), sx10(cap_ai[k][l]), tbl[t].ai);
      check($sformatf("%s b%0d l%0d sub_r", tag, tbl[t].beat, l), sx10(cap_sr[k][l]), tbl[t].sr);
      check($sformatf("%s b%0d l%0d sub_i", tag, tbl[t].beat, l), sx10(cap_si[k][l]), tbl[t].si);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " dout_valid"}, int'(dout_valid), 0);
    check({tag, " bufly_enable"}, int'(bufly_enable), 0);
    check({tag, " add_r0"}, sx10(dout_add_r[0]), 0);
    check({tag, " add_i3"}, sx10(dout_add_i[3]), 0);
    check({tag, " sub_r0"}, sx10(dout_sub_r[0]), 0);
    check({tag, " sub_i15"}, sx10(dout_sub_i[15]), 0);
  endtask

  initial begin
    tbl[0] = '{16, 0, -256, -56, 256, 256};
    tbl[1] = '{16, 15, -226, -26, 256, 256};
    tbl[2] = '{31, 0, 224, -88, 256, -256};
    tbl[3] = '{31, 15, 254, -58, 256, -256};
    tbl[4] = '{20, 3, -122, 78, 256, 256};
    for (int i = 0; i < 16; i++) begin
      din_i[i] = '0;
      din_q[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rstn = 1'b1;

    fill_ramp();
    clear_cap();
    run_frame(1'b0, "ramp");
    check_table("ramp");
    check_model("ramp");

    clear_cap();
    run_frame(1'b1, "gaps");
    check_table("gaps");
    check_model("gaps");

    for (int j = 0; j < 10; j++) begin
      din_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
        din_i[i] = vi[j][i];
        din_q[i] = vq[j][i];
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    #3 rstn = 1'b0;
    #1 check_zero("midframe_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_cap();
    run_frame(1'b0, "post_reset");
    check_table("post_reset");

    for (int j = 0; j < 32; j++)
      for (int i = 0; i < 16; i++) begin
        vi[j][i] = '0;
        vq[j][i] = '0;
      end
    vi[0][0] = 9'h100; vi[16][0] = 9'h100;
    vq[0][0] = 9'h100; vq[16][0] = 9'h100;
    vi[0][1] = 9'h0FF; vi[16][1] = 9'h100;
    vq[0][1] = 9'h0FF; vq[16][1] = 9'h100;
    clear_cap();
    run_frame(1'b0, "extreme");
    check("extreme min+min add_r", sx10(cap_ar[0][0]), -512);
    check("extreme min+min sub_r", sx10(cap_sr[0][0]), 0);
    check("extreme min+min add_i", sx10(cap_ai[0][0]), -512);
    check("extreme max-min add_r", sx10(cap_ar[0][1]), -1);
    check("extreme max-min sub_r", sx10(cap_sr[0][1]), 511);
    check("extreme max-min sub_i", sx10(cap_si[0][1]), 511);

    bufly_total = 0;
    fill_ramp();
    clear_cap();
    run_frame(1'b0, "b2b_first");
    clear_cap();
    run_frame(1'b0, "b2b_second");
    check_table("b2b_second");
    check("b2b bufly_total", bufly_total, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
